// File: rtl/dnn_feed_pkg.sv
// Shared types and default constants for the DNN input-feed sequencer.
package dnn_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRST,
    ST_RUN,
    ST_FIN
  } state_e;

  localparam int DEF_WORD_W       = 128;
  localparam int DEF_FIRST_IDX    = 2;
  localparam int DEF_LAST_IDX     = 50;
  localparam int DEF_RST_CYCLES   = 4;
  localparam int DEF_NUM_SAMPLES  = 12544;
  localparam int DEF_CAPTURE_FROM = 12344;
  localparam int DEF_ANS_W        = 10;

endpackage

// File: rtl/dnn_feed_window.sv
// Decodes the DNN cycle position into the "input word expected" flag.
module dnn_feed_window #(
  parameter int FIRST_IDX = 2,
  parameter int LAST_IDX  = 50
) (
  input  logic [6:0] cycle_index_i,
  output logic       in_win_o
);

  localparam logic [6:0] LO = 7'(FIRST_IDX);
  localparam logic [6:0] HI = 7'(LAST_IDX);

  assign in_win_o = (cycle_index_i >= LO) && (cycle_index_i <= HI);

endmodule

// File: rtl/dnn_feed_sequencer.sv
// Sequences one DNN run: reset pulse, FIFO feed during the data window, answer capture.
// Optional sticky starvation flag enabled by defining FEED_UNDERRUN_CHK_EN.
module dnn_feed_sequencer
  import dnn_feed_pkg::*;
#(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int FIRST_IDX    = DEF_FIRST_IDX,
  parameter int LAST_IDX     = DEF_LAST_IDX,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
  parameter int CAPTURE_FROM = DEF_CAPTURE_FROM,
  parameter int ANS_W        = DEF_ANS_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_dout,
  input  logic [6:0]        cycle_index,
  input  logic              cycle_clk,
  input  logic [63:0]       actL_alln,
  output logic              fifo_rd,
  output logic [WORD_W-1:0] act0,
  output logic              dnn_reset,
  output logic              busy,
  output logic              done,
  output logic              ans_valid,
  output logic [ANS_W-1:0]  ans_data,
  output logic [15:0]       sample_count,
  output logic              underrun
);

  localparam int             RCW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST    = RCW'(RST_CYCLES - 1);
  localparam logic [15:0]    CAP_FROM    = 16'(CAPTURE_FROM);
  localparam logic [15:0]    LAST_SAMPLE = 16'(NUM_SAMPLES - 1);

  state_e             state_q;
  logic [RCW-1:0]     rst_cnt_q;
  logic               dnn_reset_q, busy_q, done_q, ans_valid_q;
  logic [ANS_W-1:0]   ans_data_q;
  logic [15:0]        cnt_q, cnt_d;
  logic               in_win, in_run, feed;

  dnn_feed_window #(
    .FIRST_IDX (FIRST_IDX),
    .LAST_IDX  (LAST_IDX)
  ) u_win (
    .cycle_index_i (cycle_index),
    .in_win_o      (in_win)
  );

  // Feed path is combinational so the FIFO head reaches the DNN in the same cycle it is popped.
  assign in_run  = (state_q == ST_RUN);
  assign feed    = in_run && in_win && !fifo_empty;
  assign fifo_rd = feed;
  assign act0    = feed ? fifo_dout : '0;
  assign cnt_d   = cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      dnn_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ans_valid_q <= 1'b0;
      ans_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      ans_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dnn_reset_q <= 1'b0;
          if (start) begin
            state_q     <= ST_DRST;
            dnn_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            rst_cnt_q   <= '0;
            cnt_q       <= '0;
          end
        end
        ST_DRST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q     <= ST_RUN;
            dnn_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RCW'(1);
          end
        end
        ST_RUN: begin
          if (cycle_clk) begin
            cnt_q <= cnt_d;
            if (cnt_q >= CAP_FROM) begin
              ans_valid_q <= 1'b1;
              ans_data_q  <= actL_alln[ANS_W-1:0];
            end
            // Last sample still gets its answer forwarded above.
            if (cnt_q == LAST_SAMPLE) begin
              state_q <= ST_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dnn_reset    = dnn_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ans_valid    = ans_valid_q;
  assign ans_data     = ans_data_q;
  assign sample_count = cnt_q;

`ifdef FEED_UNDERRUN_CHK_EN
  logic underrun_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              underrun_q <= 1'b0;
    else if (state_q == ST_IDLE && start)   underrun_q <= 1'b0;
    else if (in_run && in_win && fifo_empty) underrun_q <= 1'b1;
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

  logic unused_act;
  assign unused_act = ^actL_alln[63:ANS_W];

endmodule
